uart_tx_serializer: RTL

UART transmit stage that sits directly downstream of the baud rate generator and consumes its one-cycle tick output.
- Accepts a parallel byte from the host-side logic with a single-cycle start strobe.
- Serialises the byte LSB-first onto the tx line: start bit, data bits, optional parity bit, stop bit(s).
- Every bit lasts exactly one baud tick period, and every line transition is aligned to a tick.

---
 rtl/uart_tx_serializer_if.sv | 24 ++
 rtl/uart_tx_serializer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer_if.sv
// Host-side handshake between the byte producer and the UART transmit serializer.
// The host presents a byte with a one-cycle strobe and watches busy/tx_done.
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 busy;
  logic                 tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s).
// Every line transition happens on a baud_tick; all outputs are registered.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   baud_tick,
  output logic                   tx,
  uart_tx_serializer_if.slave    bus
);
  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;

  state_t               state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    parity_next   = parity_reg;
    tx_next       = tx_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        // A tick in the acceptance cycle is deliberately ignored; SYNC waits for the next one.
        if (bus.tx_start && !busy_reg) begin
          shift_next  = bus.tx_data;
          parity_next = 1'b0;
          busy_next   = 1'b1;
          state_next  = SYNC;
        end
      end
      SYNC: begin
        if (baud_tick) begin
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_next      = shift_reg[0];
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          parity_next = parity_reg ^ shift_reg[0];
          if (bit_cnt_reg == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_next    = parity_reg ^ shift_reg[0] ^ ODD_BIT;
              state_next = PARITY;
            end else begin
              tx_next       = 1'b1;
              stop_cnt_next = 1'b0;
              state_next    = STOP;
            end
          end else begin
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          tx_next       = 1'b1;
          stop_cnt_next = 1'b0;
          state_next    = STOP;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (baud_tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign tx          = tx_reg;
  assign bus.busy    = busy_reg;
  assign bus.tx_done = done_reg;
endmodule
